// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial ripple adder, one full-adder slice, LSB first
// Result is {carry_out, sum} = a + b + c_in after WIDTH ADD edges.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_bit;
  logic             w_carry;
  logic [WIDTH-1:0] w_sh_next;
  logic             w_last;

  assign w_bit     = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_carry   = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_carry & r_b[0]);
  // New bit enters at the MSB; written as a shift/or so WIDTH=1 needs no special case.
  assign w_sh_next = (r_sh >> 1) | (WIDTH'(w_bit) << (WIDTH - 1));
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_sh      <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (r_state)
        ADD: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_sh    <= w_sh_next;
          r_carry <= w_carry;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            sum       <= w_sh_next;
            carry_out <= w_carry;
            r_state   <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= c_in;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_state <= ADD;
            busy    <= 1'b1;
          end else begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder (WIDTH=8 and WIDTH=1)
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       c_in = 1'b0;
  logic       busy, done, carry_out;
  logic [7:0] sum;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       c_in1 = 1'b0;
  logic       busy1, done1, carry_out1;
  logic [0:0] sum1;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] q8[$];
  logic [1:0] q1[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .c_in(c_in1),
    .busy(busy1), .done(done1), .sum(sum1), .carry_out(carry_out1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop the expected result whenever a done pulse is seen
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q8.size() == 0) check("w8_unexpected_done", 1, 0);
      else check("w8_result", {55'd0, carry_out, sum}, {55'd0, q8.pop_front()});
    end
    if (done1 === 1'b1) begin
      if (q1.size() == 0) check("w1_unexpected_done", 1, 0);
      else check("w1_result", {62'd0, carry_out1, sum1}, {62'd0, q1.pop_front()});
    end
  end

  // Counts negedges from the accepting edge up to the done cycle; flags busy gaps.
  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    do begin
      @(negedge clk);
      n++;
      if (!done && !busy) nb++;
    end while (!done && n < 50);
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                       input logic [8:0] exp, input string name);
    int n, nb;
    a = ia; b = ib; c_in = ic; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    q8.push_back(exp);
    wait_done(n, nb);
    check({name, "_latency"}, n, 9);
    check({name, "_busy_gap"}, nb, 0);
    check({name, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    check({name, "_done_one_cycle"}, done, 0);
  endtask

  initial begin
    int n, nb, nd;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_carry", carry_out, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    do_op(8'h5A, 8'h33, 1'b0, 9'h08D, "op_5a_33");
    check("hold_sum_idle", sum, 8'h8D);

    // Reset mid-operation abandons it and clears outputs at once
    @(negedge clk);
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_sum", sum, 0);
    check("arst_carry", carry_out, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("arst_no_done", nd, 0);

    do_op(8'hFF, 8'h01, 1'b0, 9'h100, "op_ff_01");
    do_op(8'hFF, 8'hFF, 1'b1, 9'h1FF, "op_ff_ff_1");

    // Start held during ADD: second request taken only in DONE
    a = 8'h10; b = 8'h01; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #2 a = 8'hAA; b = 8'h55;
    q8.push_back(9'h011);
    q8.push_back(9'h0FF);
    wait_done(n, nb);
    check("held_lat1", n, 9);
    @(posedge clk); #2 start = 1'b0;
    wait_done(n, nb);
    check("held_lat2", n, 9);
    @(negedge clk);
    check("held_no_third", done, 0);

    // Back-to-back: start high for three operations
    a = 8'h01; b = 8'h02; c_in = 1'b0; start = 1'b1;
    q8.push_back(9'h003);
    q8.push_back(9'h007);
    q8.push_back(9'h100);
    @(posedge clk); #2 a = 8'h03; b = 8'h04;
    wait_done(n, nb);
    check("b2b_lat1", n, 9);
    @(posedge clk); #2 a = 8'h80; b = 8'h80;
    repeat (4) @(negedge clk);
    check("b2b_hold1", sum, 8'h03);
    wait_done(n, nb);
    check("b2b_gap2", n, 5);
    @(posedge clk); #2 start = 1'b0;
    repeat (4) @(negedge clk);
    check("b2b_hold2", {carry_out, sum}, 9'h007);
    wait_done(n, nb);
    check("b2b_gap3", n, 5);
    @(negedge clk);
    check("b2b_end", done, 0);
    check("b2b_final_hold", {carry_out, sum}, 9'h100);

    // WIDTH=1 instance
    a1 = 1'b1; b1 = 1'b1; c_in1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #2 start1 = 1'b0;
    q1.push_back(2'b11);
    @(negedge clk);
    check("w1_busy", busy1, 1);
    check("w1_not_done_yet", done1, 0);
    @(negedge clk);
    check("w1_done", done1, 1);
    @(negedge clk);
    check("w1_done_cleared", done1, 0);

    repeat (2) @(negedge clk);
    check("q8_drained", q8.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
